mips_instr_issue: RTL and testbench
===================================

Name: mips_instr_issue

Overview:
Fetch-and-issue front end that supplies instructions to mips_control and the datapath. It owns the PC and requests words from instruction memory with a single-outstanding handshake. It splits each word into op_code/funct/register/immediate fields and presents them to decode with a valid/ready handshake. The datapath can redirect the PC for BEQ/BNE, J/JAL and JR.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned
CNT_W, 16, width of issued-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request; level, held until imem_valid
imem_addr  out  32  fetch address; stable while imem_req=1
imem_valid  in  1  response strobe, 1 cycle, >=1 cycle after request
imem_rdata  in  32  instruction word, valid with imem_valid
issue_valid  out  1  decoded fields valid
issue_ready  in  1  decode/datapath accepts instruction
op_code  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm16  out  16  instr[15:0]
target26  out  26  instr[25:0]
pc_plus4  out  32  address of issued instr + 4 (JAL link value)
redirect_valid  in  1  datapath redirect request
redirect_pc  in  32  new PC; bits [1:0] ignored (forced 00)
issue_count  out  CNT_W  number of completed issue handshakes

Behaviour:
- States: REQ, WAIT, HOLD. Reset (reset_n=0 at edge) -> REQ, pc=RESET_PC, discard=0, all outputs 0, issue_count=0.
- REQ: imem_req=1, imem_addr=pc. Next state is WAIT. No request is issued while reset_n=0.
- WAIT: imem_req=1, imem_addr=pc. On imem_valid with discard=0: latch imem_rdata, pc<=pc+4, go to HOLD.
  - On imem_valid with discard=1: drop data, clear discard, go to REQ.
- HOLD: issue_valid=1. All field outputs and pc_plus4 stay stable until handshake.
  - Handshake = issue_valid & issue_ready: issue_count+1 (wraps), go to REQ.
- Minimum issue period is 3 cycles (REQ, WAIT with 1-cycle memory, HOLD).
- pc_plus4 equals the latched fetch address + 4, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Fields are outputs of pure bit-slicing of the latched word. They read 0 outside HOLD.
- Redirect (redirect_valid=1) has highest priority. pc <= {redirect_pc[31:2],2'b00}.
  - In REQ: go to WAIT using the new pc (no stale request was outstanding).
  - In WAIT with no imem_valid this cycle: set discard=1 and stay in WAIT. imem_addr switches to the new pc, but memory still returns the old response, which is dropped. Then REQ re-fetches.
  - In WAIT with imem_valid the same cycle: drop the data, go to REQ.
  - In HOLD: kill the held instruction. issue_valid drops next cycle and the state goes to REQ. If issue_ready=1 in the same cycle, the handshake is voided and issue_count does not increment.
  - Back-to-back redirects: the last one wins. Only one discard is ever pending, because memory has at most one outstanding response.
- imem_valid outside WAIT is ignored.
- Reset asserted mid-operation: all state clears at the edge. A response from memory that is outstanding at reset is ignored, because the block is not in WAIT at that point.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE=000000, OP_J=000010, OP_JAL=000011, OP_BEQ=000100, OP_BNE=000101, OP_LW=100011, OP_SW=101011
  - funct constants: F_ADD=100000, F_SUB=100010, F_JR=001000
  - field bit-position localparams
  - the issue state enum {REQ, WAIT, HOLD}
- One sub-module, mips_instr_fields: combinational 32-bit word -> op_code/rs/rt/rd/shamt/funct/imm16/target26 splitter, shared with the testbenches.

Test Plan:
- Reset release, memory returns 32'h8C22_0004 (LW) after 1 cycle, issue_ready=1 -> imem_addr=0; op_code=100011, rs=1, rt=2, imm16=0004, pc_plus4=4; issue_count=1.
- Sequential stream 0x0000_0822 (SUB), 0x0000_0007, 0x0000_0823 with ready always 1 -> imem_addr 0,4,8 on successive requests; funct=100010, 000111, 100011 in order; issue every 3 cycles.
- Backpressure: issue_ready low for 5 cycles in HOLD on 0x0800_0010 (J) -> issue_valid held; op_code=000010 and target26=0x10 stable; no new imem_req until accept.
- Redirect in WAIT to 32'h0000_0043 with memory answering 2 cycles later -> stale word dropped, next imem_addr=32'h0000_0040, issued pc_plus4=32'h0000_0044.
- Redirect in HOLD coincident with issue_ready=1 -> instruction killed, issue_count unchanged, next fetch from redirect_pc.
- RESET_PC=32'hFFFF_FFFC -> pc_plus4=0, next imem_addr=0; reset_n low mid-WAIT -> pc returns to RESET_PC, late imem_valid ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS fetch/issue front end.
//   - opcode and funct constants used by decode and testbenches
//   - bit positions of each instruction field
//   - state encoding of the fetch/issue controller
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_JR     = 6'b001000;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } issue_state_t;

endpackage

// File: rtl/mips_instr_fields.sv
// mips_instr_fields: purely combinational splitter of a 32-bit MIPS word.
// Ports:
//   word      in  32  instruction word
//   op_code   out 6   [31:26]    rs    out 5  [25:21]
//   rt        out 5   [20:16]    rd    out 5  [15:11]
//   shamt     out 5   [10:6]     funct out 6  [5:0]
//   imm16     out 16  [15:0]     target26 out 26 [25:0]
module mips_instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] word,
  output logic [5:0]  op_code,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] target26
);

  assign op_code  = word[OP_MSB:OP_LSB];
  assign rs       = word[RS_MSB:RS_LSB];
  assign rt       = word[RT_MSB:RT_LSB];
  assign rd       = word[RD_MSB:RD_LSB];
  assign shamt    = word[SH_MSB:SH_LSB];
  assign funct    = word[FN_MSB:FN_LSB];
  assign imm16    = word[IMM_MSB:IMM_LSB];
  assign target26 = word[TGT_MSB:TGT_LSB];

endmodule

// File: rtl/mips_instr_issue.sv
// mips_instr_issue: PC owner, single-outstanding instruction fetch and
// valid/ready issue of the decoded fields.
// Ports:
//   clk, reset_n (sync, active-low)
//   imem_req/imem_addr      fetch request (level) and address
//   imem_valid/imem_rdata   one-cycle response strobe and word
//   issue_valid/issue_ready issue handshake
//   op_code..target26       fields of the held word, zero when not holding
//   pc_plus4                fetch address of held word + 4 (link value)
//   redirect_valid/redirect_pc  datapath PC override, highest priority
//   issue_count             completed issue handshakes (wraps)
module mips_instr_issue
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [5:0]       op_code,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      target26,
  output logic [31:0]      pc_plus4,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] issue_count
);

  issue_state_t     state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic             discard, discard_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             latch_en;
  logic [31:0]      redirect_aligned;
  logic [31:0]      instr_p0;
  logic [31:0]      word_p1;
  logic             hold;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    count_nxt   = count;
    latch_en    = 1'b0;
    case (state)
      REQ: begin
        state_nxt = WAIT;
        if (redirect_valid) pc_nxt = redirect_aligned;
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_aligned;
          if (imem_valid) begin
            // The arriving response belongs to the old PC; nothing else is
            // outstanding, so re-fetch from the new PC.
            state_nxt   = REQ;
            discard_nxt = 1'b0;
          end else begin
            // Old response still in flight: drop it when it arrives.
            discard_nxt = 1'b1;
          end
        end else if (imem_valid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = REQ;
          end else begin
            latch_en  = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // Redirect kills the held word and voids a coincident handshake.
        if (redirect_valid) begin
          pc_nxt    = redirect_aligned;
          state_nxt = REQ;
        end else if (issue_ready) begin
          count_nxt = count + CNT_W'(1);
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      count   <= count_nxt;
    end
  end

  // Stage p0: captured instruction word (data only, no reset)
  always_ff @(posedge clk) begin
    if (latch_en) instr_p0 <= imem_rdata;
  end

  // Stage p1: outputs gated to zero outside HOLD
  assign hold        = (state == HOLD);
  assign imem_req    = reset_n & ((state == REQ) | (state == WAIT));
  assign imem_addr   = imem_req ? pc : 32'd0;
  assign issue_valid = hold;
  assign word_p1     = hold ? instr_p0 : 32'd0;
  // pc already advanced past the held word, so it is the link value.
  assign pc_plus4    = hold ? pc : 32'd0;
  assign issue_count = count;

  mips_instr_fields u_fields (
    .word     (word_p1),
    .op_code  (op_code),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16),
    .target26 (target26)
  );

endmodule

// File: tb/tb_mips_instr_issue.sv
// tb_mips_instr_issue: directed and randomized bench for mips_instr_issue.
// A second instance with RESET_PC at the top of the address space covers the
// pc_plus4 wrap.
module tb_mips_instr_issue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  op_code;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] issue_count;

  logic        b_imem_req;
  logic [31:0] b_imem_addr;
  logic        b_imem_valid;
  logic [31:0] b_imem_rdata;
  logic        b_issue_valid;
  logic        b_issue_ready;
  logic [5:0]  b_op_code;
  logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
  logic [5:0]  b_funct;
  logic [15:0] b_imm16;
  logic [25:0] b_target26;
  logic [31:0] b_pc_plus4;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic [15:0] b_issue_count;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_pc;
  int          model_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_instr_issue dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target26(target26),
    .pc_plus4(pc_plus4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue_count(issue_count)
  );

  mips_instr_issue #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_top (
    .clk(clk), .reset_n(reset_n),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_valid(b_imem_valid), .imem_rdata(b_imem_rdata),
    .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .op_code(b_op_code), .rs(b_rs), .rt(b_rt), .rd(b_rd), .shamt(b_shamt),
    .funct(b_funct), .imm16(b_imm16), .target26(b_target26),
    .pc_plus4(b_pc_plus4),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .issue_count(b_issue_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected fields are taken straight from the MIPS encoding of the word.
  task automatic chk_hold(input logic [31:0] w, input logic [31:0] addr);
    chk("issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("hold_no_req", {31'd0, imem_req}, 32'd0);
    chk("op_code", {26'd0, op_code}, {26'd0, w[31:26]});
    chk("rs", {27'd0, rs}, {27'd0, w[25:21]});
    chk("rt", {27'd0, rt}, {27'd0, w[20:16]});
    chk("rd", {27'd0, rd}, {27'd0, w[15:11]});
    chk("shamt", {27'd0, shamt}, {27'd0, w[10:6]});
    chk("funct", {26'd0, funct}, {26'd0, w[5:0]});
    chk("imm16", {16'd0, imm16}, {16'd0, w[15:0]});
    chk("target26", {6'd0, target26}, {6'd0, w[25:0]});
    chk("pc_plus4", pc_plus4, addr + 32'd4);
  endtask

  task automatic reset_all();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    model_pc  = 32'd0;
    model_cnt = 0;
  endtask

  // Entered in REQ; leaves in WAIT.
  task automatic do_req(input logic redir, input logic [31:0] rpc);
    chk("req", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, model_pc);
    if (redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc;
      model_pc       = rpc & 32'hFFFF_FFFC;
    end
    step();
    redirect_valid = 1'b0;
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    chk("wait_addr", imem_addr, model_pc);
  endtask

  // Entered in WAIT; memory answers after lat cycles, decode stalls hold cycles.
  task automatic do_wait_issue(input int lat, input logic [31:0] w, input int hold);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("wait_stall_addr", imem_addr, model_pc);
      chk("wait_no_issue", {31'd0, issue_valid}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    chk_hold(w, model_pc);
    for (int h = 0; h < hold; h++) begin
      step();
      chk_hold(w, model_pc);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    model_pc  = model_pc + 32'd4;
    model_cnt = model_cnt + 1;
    chk("issue_count", {16'd0, issue_count}, model_cnt & 32'hFFFF);
    chk("post_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("post_issue_op", {26'd0, op_code}, 32'd0);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, model_pc);
  endtask

  task automatic fetch_issue(input logic [31:0] w, input int lat, input int hold);
    do_req(1'b0, 32'd0);
    do_wait_issue(lat, w, hold);
  endtask

  initial begin
    logic [31:0] w;
    int          t0;
    reset_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = 32'd0; issue_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    b_imem_valid = 1'b0; b_imem_rdata = 32'd0; b_issue_ready = 1'b0;
    b_redirect_valid = 1'b0; b_redirect_pc = 32'd0;
    model_pc = 32'd0;
    model_cnt = 0;

    // Reset state, sampled while reset_n is still low
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_count", {16'd0, issue_count}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    chk("rst_op", {26'd0, op_code}, 32'd0);
    reset_n = 1'b1;
    #1;

    // LW, one-cycle memory, ready immediately
    fetch_issue(32'h8C22_0004, 1, 0);

    // Sequential stream from a fresh reset at the minimum issue period
    reset_all();
    t0 = cyc;
    fetch_issue(32'h0000_0822, 1, 0);
    fetch_issue(32'h0000_0007, 1, 0);
    fetch_issue(32'h0000_0823, 1, 0);
    chk("issue_period", cyc - t0, 32'd9);

    // Backpressure on a J
    fetch_issue(32'h0800_0010, 1, 5);

    // Redirect in WAIT, stale response two cycles after the request
    do_req(1'b0, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    model_pc = 32'h0000_0040;
    chk("redir_wait_addr", imem_addr, 32'h0000_0040);
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_valid = 1'b0;
    chk("stale_dropped", {31'd0, issue_valid}, 32'd0);
    fetch_issue(32'h0C00_0040, 1, 0);

    // Redirect in HOLD coincident with issue_ready
    do_req(1'b0, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 32'h1085_FFFE;
    step();
    imem_valid = 1'b0;
    chk_hold(32'h1085_FFFE, model_pc);
    issue_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    model_pc = 32'h0000_0100;
    chk("kill_valid", {31'd0, issue_valid}, 32'd0);
    chk("kill_count", {16'd0, issue_count}, model_cnt & 32'hFFFF);
    chk("kill_next_addr", imem_addr, 32'h0000_0100);

    // Redirect in WAIT on the same cycle as the response
    do_req(1'b0, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    imem_valid     = 1'b1;
    imem_rdata     = 32'hAAAA_5555;
    step();
    redirect_valid = 1'b0;
    imem_valid     = 1'b0;
    model_pc = 32'h0000_0200;
    chk("coinc_valid", {31'd0, issue_valid}, 32'd0);
    // Redirect in REQ, then a slow memory and a short stall
    do_req(1'b1, 32'h0000_0303);
    do_wait_issue(2, 32'h03E0_0008, 1);

    // Reset mid-WAIT; a late response during REQ must be ignored
    do_req(1'b0, 32'd0);
    reset_n = 1'b0;
    step();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_count", {16'd0, issue_count}, 32'd0);
    reset_n    = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    model_pc  = 32'd0;
    model_cnt = 0;
    chk("midrst_addr", imem_addr, 32'd0);
    step();
    imem_valid = 1'b0;
    chk("late_valid_ignored", {31'd0, issue_valid}, 32'd0);
    chk("late_wait_addr", imem_addr, 32'd0);
    do_wait_issue(1, 32'hAC43_0010, 0);

    // Randomized stream with occasional redirects in REQ
    for (int n = 0; n < 40; n++) begin
      logic redir;
      w     = $urandom;
      redir = ($urandom_range(0, 3) == 0);
      do_req(redir, $urandom);
      do_wait_issue($urandom_range(1, 3), w, $urandom_range(0, 3));
    end

    // Second instance: pc_plus4 wraps from the top of memory
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("top_req", {31'd0, b_imem_req}, 32'd1);
    chk("top_addr", b_imem_addr, 32'hFFFF_FFFC);
    step();
    b_imem_valid = 1'b1;
    b_imem_rdata = 32'h0000_0820;
    step();
    b_imem_valid = 1'b0;
    chk("top_valid", {31'd0, b_issue_valid}, 32'd1);
    chk("top_pc_plus4", b_pc_plus4, 32'd0);
    chk("top_funct", {26'd0, b_funct}, 32'h20);
    b_issue_ready = 1'b1;
    step();
    b_issue_ready = 1'b0;
    chk("top_wrap_addr", b_imem_addr, 32'd0);
    chk("top_count", {16'd0, b_issue_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
